button_events: RTL and testbench
================================

Name: button_events

Overview:
- Reads the board's raw push-buttons and turns them into clean, single-cycle user events: press, release, long-press and auto-repeat.
- Feeds control logic such as LED-counter run/pause, step and speed.
- Acts as the input-side counterpart of the LED output path.
- One instance handles all buttons; each button has its own synchroniser, debouncer and event FSM, and the channels are fully independent.

Parameters:
- N_BTN, 2: number of buttons.
- DEBOUNCE_CYCLES, 270000: consecutive cycles a changed level must persist before it is accepted. 10 ms at 27 MHz. Must be ≥1.
- LONG_CYCLES, 13500000: cycles from accepted press to long_pulse. 0.5 s. Must be ≥1.
- REPEAT_CYCLES, 2700000: auto-repeat period after long-press. 100 ms. Must be ≥1.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- btn, in, N_BTN: raw buttons, active-low (0 = pressed), asynchronous to clk.
- pressed, out, N_BTN: debounced level, active-high.
- press_pulse, out, N_BTN: 1-cycle strobe on accepted press.
- release_pulse, out, N_BTN: 1-cycle strobe on accepted release.
- long_pulse, out, N_BTN: 1-cycle strobe when hold reaches LONG_CYCLES.
- repeat_pulse, out, N_BTN: 1-cycle strobe every REPEAT_CYCLES while held past long-press.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Synchroniser flops = 1 (released).
  - Debounced state = released.
  - All counters = 0; FSM = IDLE.
  - All outputs = 0.
  - Reset mid-hold discards everything; no pulses on release from reset.
- Synchroniser:
  - 2 flops per bit; the debouncer sees only the second flop (sync).
- Debouncer, per bit:
  - db_cnt is sized $clog2(DEBOUNCE_CYCLES+1).
  - sync == accepted level: db_cnt <= 0.
  - sync != accepted level: db_cnt increments. On the cycle db_cnt == DEBOUNCE_CYCLES-1, the accepted level toggles and db_cnt <= 0.
  - Any return to the accepted level before then clears db_cnt, so glitches produce no event.
  - Latency: a raw level held steady causes pressed to change and the strobe to assert DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
- Event FSM, per bit. hold_cnt is sized $clog2(max(LONG_CYCLES,REPEAT_CYCLES)+1).
  - IDLE:
    - On accepted press: pressed<=1, press_pulse=1, hold_cnt<=0, go to HOLD.
  - HOLD:
    - hold_cnt increments each cycle.
    - When hold_cnt == LONG_CYCLES-1: long_pulse=1 (LONG_CYCLES cycles after press_pulse), hold_cnt<=0, go to REPEAT.
    - On accepted release: release_pulse=1, pressed<=0, go to IDLE, no long_pulse.
  - REPEAT:
    - hold_cnt increments.
    - When hold_cnt == REPEAT_CYCLES-1: repeat_pulse=1, hold_cnt<=0.
    - Accepted release: release_pulse=1, go to IDLE.
  - Release has priority: if release is accepted on the same cycle a long or repeat would fire, only release_pulse asserts.
- Output rules:
  - All pulses are registered and exactly one cycle wide.
  - At most one of the four pulses is high per bit per cycle.
  - pressed equals the debounced level at all times.
- Channels are fully independent; simultaneous events on different bits all assert in the same cycle.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, N_BTN=2):
- Reset: rst_n low with btn=2'b00, held arbitrarily → all outputs 0. After release, btn[0] held low → press_pulse[0] exactly 6 edges later; pressed[0]=1 the same cycle.
- Glitch rejection: btn[0] low for 3 cycles, then high → no pulses; pressed stays 0. Then low for 4+ cycles → single press_pulse.
- Short press: press held 10 cycles after press_pulse, then raw release → release_pulse 6 edges after the raw rise; no long_pulse.
- Long + repeat: hold 60 cycles → long_pulse 20 cycles after press_pulse, then repeat_pulse at +8, +16, +24 …; release gives release_pulse only.
- Simultaneous: both buttons pressed on the same edge → press_pulse=2'b11 in one cycle. Release btn[1] only → release_pulse=2'b10; btn[0] continues to long_pulse.
- Async reset mid-REPEAT: rst_n pulsed low → outputs 0 immediately. With button still held after reset, a fresh press_pulse follows 6 edges later.

Source files
------------

// File: rtl/button_events.sv
// Purpose: debounce raw active-low push-buttons into press/release/long/repeat strobes.
// Latency: a steady raw change shows on pressed and its strobe DEBOUNCE_CYCLES+2 edges after first sampled.
// Backpressure: none; strobes are single-cycle and must be consumed when asserted.
module button_events #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 13500000,
    parameter int REPEAT_CYCLES   = 2700000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse
);

    // Counter widths: the debounce counter never exceeds DEBOUNCE_CYCLES-1 and the
    // hold counter is shared between the long-press and repeat intervals.
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    genvar g;
    generate
        for (g = 0; g < N_BTN; g++) begin : g_chan

            // Synchroniser: raw polarity kept (1 = released) so reset means released.
            logic sync1_q;
            logic sync2_q;

            // Debouncer state: accepted level is active-high (1 = pressed).
            logic            level_q;
            logic            level_d;
            logic [DB_W-1:0] db_cnt_q;
            logic [DB_W-1:0] db_cnt_d;
            logic            raw_pressed;
            logic            acc_press;
            logic            acc_release;

            // Event FSM state and registered strobes.
            state_t              state_q;
            state_t              state_d;
            logic [HOLD_W-1:0]   hold_cnt_q;
            logic [HOLD_W-1:0]   hold_cnt_d;
            logic                press_q;
            logic                press_d;
            logic                release_q;
            logic                release_d;
            logic                long_q;
            logic                long_d;
            logic                repeat_q;
            logic                repeat_d;

            // Two-flop synchroniser for the asynchronous button input.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                end else begin
                    sync1_q <= btn[g];
                    sync2_q <= sync1_q;
                end
            end

            assign raw_pressed = ~sync2_q;

            // Debounce: count consecutive disagreeing samples, accept on the last one.
            always_comb begin
                level_d     = level_q;
                db_cnt_d    = '0;
                acc_press   = 1'b0;
                acc_release = 1'b0;
                if (raw_pressed != level_q) begin
                    if (db_cnt_q == DB_LAST) begin
                        level_d     = ~level_q;
                        db_cnt_d    = '0;
                        acc_press   = ~level_q;
                        acc_release = level_q;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
            end

            // Debounce registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    level_q  <= 1'b0;
                    db_cnt_q <= '0;
                end else begin
                    level_q  <= level_d;
                    db_cnt_q <= db_cnt_d;
                end
            end

            // Event FSM: release always wins over a long or repeat due the same cycle.
            always_comb begin
                state_d    = state_q;
                hold_cnt_d = hold_cnt_q;
                press_d    = 1'b0;
                release_d  = 1'b0;
                long_d     = 1'b0;
                repeat_d   = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (acc_press) begin
                            press_d    = 1'b1;
                            hold_cnt_d = '0;
                            state_d    = ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (acc_release) begin
                            release_d  = 1'b1;
                            hold_cnt_d = '0;
                            state_d    = ST_IDLE;
                        end else if (hold_cnt_q == LONG_LAST) begin
                            long_d     = 1'b1;
                            hold_cnt_d = '0;
                            state_d    = ST_REPEAT;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (acc_release) begin
                            release_d  = 1'b1;
                            hold_cnt_d = '0;
                            state_d    = ST_IDLE;
                        end else if (hold_cnt_q == REPEAT_LAST) begin
                            repeat_d   = 1'b1;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        hold_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end
                endcase
            end

            // FSM state, hold counter and strobe registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q    <= ST_IDLE;
                    hold_cnt_q <= '0;
                    press_q    <= 1'b0;
                    release_q  <= 1'b0;
                    long_q     <= 1'b0;
                    repeat_q   <= 1'b0;
                end else begin
                    state_q    <= state_d;
                    hold_cnt_q <= hold_cnt_d;
                    press_q    <= press_d;
                    release_q  <= release_d;
                    long_q     <= long_d;
                    repeat_q   <= repeat_d;
                end
            end

            assign pressed[g]       = level_q;
            assign press_pulse[g]   = press_q;
            assign release_pulse[g] = release_q;
            assign long_pulse[g]    = long_q;
            assign repeat_pulse[g]  = repeat_q;
        end
    endgenerate

endmodule

// File: tb/tb_button_events.sv
// Purpose: directed checks of button_events with short debounce/long/repeat intervals.
// Latency: outputs sampled on the falling edge; k counts rising edges since the last input change.
// Backpressure: not applicable.
module tb_button_events;
    localparam int N_BTN = 2;
    localparam int DB    = 4;
    localparam int LONG  = 20;
    localparam int RPT   = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] long_pulse;
    logic [N_BTN-1:0] repeat_pulse;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    button_events #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LONG),
        .REPEAT_CYCLES  (RPT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn          (btn),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse)
    );

    task automatic step();
        @(negedge clk);
    endtask

    // {pressed, press, release, long, repeat}, two bits each.
    function automatic logic [9:0] outs();
        return {pressed, press_pulse, release_pulse, long_pulse, repeat_pulse};
    endfunction

    task automatic test_reset();
        logic [9:0] exp;
        rst_n = 1'b0;
        btn   = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            step();
            vectors++;
            if (outs() !== 10'b0) begin
                errors++;
                $display("FAIL reset_hold k=%0d got %b exp %b", k, outs(), 10'b0);
            end
        end
        rst_n = 1'b1;
        btn   = 2'b10;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp = {1'b0, k >= 6, 1'b0, k == 6, 6'b0};
            vectors++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL reset_first_press k=%0d got %b exp %b", k, outs(), exp);
            end
        end
        btn = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp = {1'b0, k < 6, 2'b00, 1'b0, k == 6, 4'b0};
            vectors++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL reset_first_release k=%0d got %b exp %b", k, outs(), exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [9:0] exp;
        btn = 2'b10;
        for (int k = 1; k <= 12; k++) begin
            step();
            vectors++;
            if (outs() !== 10'b0) begin
                errors++;
                $display("FAIL glitch_reject k=%0d got %b exp %b", k, outs(), 10'b0);
            end
            if (k == 3) btn = 2'b11;
        end
        btn = 2'b10;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp = {1'b0, k >= 6, 1'b0, k == 6, 6'b0};
            vectors++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL glitch_then_press k=%0d got %b exp %b", k, outs(), exp);
            end
        end
        btn = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp = {1'b0, k < 6, 2'b00, 1'b0, k == 6, 4'b0};
            vectors++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL glitch_release k=%0d got %b exp %b", k, outs(), exp);
            end
        end
    endtask

    task automatic test_short_press();
        logic [9:0] exp;
        btn = 2'b10;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp = {1'b0, k >= 6, 1'b0, k == 6, 6'b0};
            vectors++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL short_hold k=%0d got %b exp %b", k, outs(), exp);
            end
        end
        btn = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp = {1'b0, k < 6, 2'b00, 1'b0, k == 6, 4'b0};
            vectors++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL short_release k=%0d got %b exp %b", k, outs(), exp);
            end
        end
    endtask

    task automatic test_long_repeat();
        logic [9:0] exp;
        logic       rep;
        btn = 2'b10;
        for (int k = 1; k <= 66; k++) begin
            step();
            rep = (k == 34) || (k == 42) || (k == 50) || (k == 58) || (k == 66);
            exp = {1'b0, k >= 6, 1'b0, k == 6, 2'b00, 1'b0, k == 26, 1'b0, rep};
            vectors++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL long_repeat_hold k=%0d got %b exp %b", k, outs(), exp);
            end
        end
        btn = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp = {1'b0, k < 6, 2'b00, 1'b0, k == 6, 4'b0};
            vectors++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL long_repeat_release k=%0d got %b exp %b", k, outs(), exp);
            end
        end
    endtask

    // Release accepted exactly when a long (k=26) or a repeat (k=34) would fire.
    task automatic test_release_priority();
        logic [9:0] exp;
        btn = 2'b10;
        for (int k = 1; k <= 28; k++) begin
            step();
            exp = {1'b0, (k >= 6) && (k < 26), 1'b0, k == 6, 1'b0, k == 26, 4'b0};
            vectors++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL prio_vs_long k=%0d got %b exp %b", k, outs(), exp);
            end
            if (k == 20) btn = 2'b11;
        end
        btn = 2'b10;
        for (int k = 1; k <= 38; k++) begin
            step();
            exp = {1'b0, (k >= 6) && (k < 34), 1'b0, k == 6, 1'b0, k == 34, 1'b0, k == 26, 2'b00};
            vectors++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL prio_vs_repeat k=%0d got %b exp %b", k, outs(), exp);
            end
            if (k == 28) btn = 2'b11;
        end
    endtask

    // Leaves btn[0] held in the HOLD state for the reset test that follows.
    task automatic test_simultaneous();
        logic [9:0] exp;
        btn = 2'b00;
        for (int k = 1; k <= 28; k++) begin
            step();
            exp = {(k >= 6) && (k < 15), k >= 6,
                   k == 6, k == 6,
                   k == 15, 1'b0,
                   1'b0, k == 26,
                   2'b00};
            vectors++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL simultaneous k=%0d got %b exp %b", k, outs(), exp);
            end
            if (k == 9) btn = 2'b10;
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] exp;
        for (int k = 29; k <= 36; k++) begin
            step();
            exp = {2'b01, 6'b0, 1'b0, k == 34};
            vectors++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL pre_reset_repeat k=%0d got %b exp %b", k, outs(), exp);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (outs() !== 10'b0) begin
            errors++;
            $display("FAIL async_reset_immediate got %b exp %b", outs(), 10'b0);
        end
        step();
        vectors++;
        if (outs() !== 10'b0) begin
            errors++;
            $display("FAIL async_reset_held got %b exp %b", outs(), 10'b0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp = {1'b0, k >= 6, 1'b0, k == 6, 6'b0};
            vectors++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL post_reset_press k=%0d got %b exp %b", k, outs(), exp);
            end
        end
        btn = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp = {1'b0, k < 6, 2'b00, 1'b0, k == 6, 4'b0};
            vectors++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL post_reset_release k=%0d got %b exp %b", k, outs(), exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 2'b11;
        test_reset();
        test_glitch();
        test_short_press();
        test_long_repeat();
        test_release_priority();
        test_simultaneous();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
